// File: rtl/ping_pong_sector_buf_if.sv
// Bus bundle for the ping-pong sector buffer.
// The write side pushes beats and flushes. The read side fetches bytes and releases banks.
interface ping_pong_sector_buf_if #(
    parameter int WR_BYTES = 4,
    parameter int DEPTH    = 512
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                    wr_valid;
    logic [8*WR_BYTES-1:0]   wr_data;
    logic                    wr_ready;
    logic                    wr_flush;
    logic                    rd_avail;
    logic [ADDR_W:0]         rd_len;
    logic                    rd_req;
    logic [ADDR_W-1:0]       rd_addr;
    logic [7:0]              rd_data;
    logic                    rd_valid;
    logic                    rd_release;

    // The master is the environment that produces beats and consumes banks.
    modport master (
        output wr_valid, wr_data, wr_flush, rd_req, rd_addr, rd_release,
        input  wr_ready, rd_avail, rd_len, rd_data, rd_valid
    );

    // The slave is the buffer itself.
    modport slave (
        input  wr_valid, wr_data, wr_flush, rd_req, rd_addr, rd_release,
        output wr_ready, rd_avail, rd_len, rd_data, rd_valid
    );
endinterface

// File: rtl/ping_pong_sector_buf.sv
// Double-buffered sector store.
// The writer fills one bank while the reader drains the other.
// A bank is handed over when it fills up or is flushed, and it is handed back on release.
module ping_pong_sector_buf #(
    parameter int WR_BYTES = 4,
    parameter int DEPTH    = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ping_pong_sector_buf_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] STEP     = (ADDR_W+1)'(WR_BYTES);
    localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(DEPTH);

    // Both banks share one array; the bank number is the top address bit.
    logic [7:0]       mem [2*DEPTH];

    logic             wb_q, wb_d;
    logic             rb_q, rb_d;
    logic [ADDR_W:0]  wp_q, wp_d;
    logic [1:0]       full_q, full_d;
    logic [ADDR_W:0]  len_q [2];
    logic [ADDR_W:0]  len_d [2];
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;

    logic             beat_acc;
    logic [ADDR_W:0]  wp_sum;
    logic             close_bank;
    logic             rel_bank;

    // Work out the bank hand-over events and the next control state.
    // Closing a bank needs it not full, which means wb != rb whenever close and release coincide.
    always_comb begin
        beat_acc   = bus.wr_valid && !full_q[wb_q];
        wp_sum     = beat_acc ? (wp_q + STEP) : wp_q;
        close_bank = !full_q[wb_q] &&
                     ((beat_acc && (wp_sum == FULL_LEN)) || (bus.wr_flush && (wp_sum != '0)));
        rel_bank   = bus.rd_release && full_q[rb_q];

        wb_d      = wb_q;
        rb_d      = rb_q;
        wp_d      = wp_sum;
        full_d    = full_q;
        len_d[0]  = len_q[0];
        len_d[1]  = len_q[1];

        if (close_bank) begin
            full_d[wb_q] = 1'b1;
            len_d[wb_q]  = wp_sum;
            wp_d         = '0;
            wb_d         = ~wb_q;
        end
        if (rel_bank) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
        end

        rd_valid_d = bus.rd_req && full_q[rb_q];
        rd_data_d  = rd_data_q;
        if (rd_valid_d) begin
            rd_data_d = mem[{rb_q, bus.rd_addr}];
        end
    end

    // Control and read-port registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            wp_q       <= '0;
            full_q     <= 2'b00;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            wp_q       <= wp_d;
            full_q     <= full_d;
            len_q[0]   <= len_d[0];
            len_q[1]   <= len_d[1];
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Byte storage, written little-endian one beat at a time; it is never cleared.
    always_ff @(posedge clk) begin
        if (rst_n && beat_acc) begin
            for (int i = 0; i < WR_BYTES; i++) begin
                mem[{wb_q, wp_q[ADDR_W-1:0] + ADDR_W'(i)}] <= bus.wr_data[8*i +: 8];
            end
        end
    end

    assign bus.wr_ready = !full_q[wb_q];
    assign bus.rd_avail = full_q[rb_q];
    assign bus.rd_len   = len_q[rb_q];
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

endmodule
